leitor_sensores_nivel: RTL and testbench

Samples the three raw float sensors of the irrigation tank (high, medium, low), synchronises and debounces them, and rejects physically impossible combinations. It drives a registered, glitch-free A/M/B level code into the tank-level 7-segment display decoder, plus status flags for the control logic. It is the producer end of the A/M/B level interface consumed by the display path.

---
 rtl/leitor_sensores_nivel.sv | 107 ++++++++++
 tb/tb_leitor_sensores_nivel.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/leitor_sensores_nivel.sv
// Float-sensor level reader: synchronises, debounces and validates the three tank sensors into an A/M/B code.
// Optional macro LEITOR_NIVEL_ERRO_STICKY_EN keeps erro latched until reset.
module leitor_sensores_nivel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_m,
    input  logic sensor_b,
    output logic A,
    output logic M,
    output logic B,
    output logic nivel_valido,
    output logic nivel_muda,
    output logic erro
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        ESTAVEL = 2'd1,
        ERRO    = 2'd2
    } estado_t;

    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    com_q;
    estado_t       estado_q;
    logic          valido_q, muda_q, erro_q;
    logic          pending, accept, candValido;

    function automatic logic validPattern(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    // A candidate is worth counting only if accepting it could change something in the current state.
    always_comb begin
        candValido = validPattern(cand_q);
        pending    = 1'b0;
        case (estado_q)
            INICIAL: pending = 1'b1;
            ESTAVEL: pending = (cand_q != com_q);
            ERRO:    pending = candValido;
            default: pending = 1'b0;
        endcase
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (pending && (cnt_q == CNT_LAST)) begin
            accept = 1'b1;
            cnt_d  = '0;
        end else if (pending) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            com_q    <= '0;
            estado_q <= INICIAL;
            valido_q <= 1'b0;
            muda_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            sync1_q <= {sensor_a, sensor_m, sensor_b};
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            muda_q  <= 1'b0;
            if (accept) begin
                if (candValido) begin
                    com_q    <= cand_q;
                    valido_q <= 1'b1;
                    muda_q   <= (cand_q != com_q);
                    estado_q <= ESTAVEL;
`ifndef LEITOR_NIVEL_ERRO_STICKY_EN
                    erro_q   <= 1'b0;
`endif
                end else begin
                    // The display keeps showing the last good level while the fault is flagged.
                    erro_q   <= 1'b1;
                    estado_q <= ERRO;
                end
            end
        end
    end

    assign {A, M, B}    = com_q;
    assign nivel_valido = valido_q;
    assign nivel_muda   = muda_q;
    assign erro         = erro_q;

endmodule

// File: tb/tb_leitor_sensores_nivel.sv
// Randomised bench for leitor_sensores_nivel: two instances (debounce 4 and 2) against a behavioural level model.
module tb_leitor_sensores_nivel;

`ifdef LEITOR_NIVEL_ERRO_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] raw = 3'b000;

    logic a4, m4, b4, val4, muda4, erro4;
    logic a2, m2, b2, val2, muda2, erro2;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    leitor_sensores_nivel #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .sensor_a(raw[2]), .sensor_m(raw[1]), .sensor_b(raw[0]),
        .A(a4), .M(m4), .B(b4),
        .nivel_valido(val4), .nivel_muda(muda4), .erro(erro4)
    );

    leitor_sensores_nivel #(.DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .sensor_a(raw[2]), .sensor_m(raw[1]), .sensor_b(raw[0]),
        .A(a2), .M(m2), .B(b2),
        .nivel_valido(val2), .nivel_muda(muda2), .erro(erro2)
    );

    // Model: a sampled pattern is acted on once it has been seen unchanged for D edges after arriving.
    typedef struct {
        logic [2:0] p1;
        logic [2:0] p2;
        logic [2:0] seen;
        int         age;
        logic [2:0] lvl;
        bit         inError;
        bit         valido;
        bit         muda;
        bit         erro;
    } model_t;

    model_t mod4, mod2;

    function automatic bit legal(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    function automatic bit worthActing(input model_t m);
        if (m.inError) return legal(m.seen);
        if (!m.valido) return 1'b1;
        return m.seen != m.lvl;
    endfunction

    function automatic model_t resetModel();
        model_t m;
        m.p1 = '0; m.p2 = '0; m.seen = '0; m.age = 0; m.lvl = '0;
        m.inError = 0; m.valido = 0; m.muda = 0; m.erro = 0;
        return m;
    endfunction

    function automatic model_t stepModel(input model_t m, input logic [2:0] r, input bit rst, input int d);
        model_t n;
        logic [2:0] arriving;
        if (rst) return resetModel();
        n = m;
        arriving = m.p2;
        n.p2 = m.p1;
        n.p1 = r;
        n.muda = 0;
        if (arriving != m.seen) begin
            n.seen = arriving;
            n.age = 0;
        end else if (m.age < d) begin
            n.age = m.age + 1;
            if (n.age == d && worthActing(m)) begin
                if (legal(m.seen)) begin
                    n.muda = (m.seen != m.lvl);
                    n.lvl = m.seen;
                    n.valido = 1;
                    n.inError = 0;
                    if (!STICKY) n.erro = 0;
                end else begin
                    n.inError = 1;
                    n.erro = 1;
                end
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("d4.amb",    {29'd0, a4, m4, b4}, {29'd0, mod4.lvl});
        checkOutput("d4.valido", {31'd0, val4},       {31'd0, mod4.valido});
        checkOutput("d4.muda",   {31'd0, muda4},      {31'd0, mod4.muda});
        checkOutput("d4.erro",   {31'd0, erro4},      {31'd0, mod4.erro});
        checkOutput("d2.amb",    {29'd0, a2, m2, b2}, {29'd0, mod2.lvl});
        checkOutput("d2.valido", {31'd0, val2},       {31'd0, mod2.valido});
        checkOutput("d2.muda",   {31'd0, muda2},      {31'd0, mod2.muda});
        checkOutput("d2.erro",   {31'd0, erro2},      {31'd0, mod2.erro});
    endtask

    // Drive one clock cycle's inputs, advance the models at the edge, compare on the falling edge.
    task automatic applyStimulus(input logic [2:0] pattern, input bit rst, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            raw = pattern;
            reset = rst;
            @(posedge clk);
            mod4 = stepModel(mod4, pattern, rst, 4);
            mod2 = stepModel(mod2, pattern, rst, 2);
            @(negedge clk);
            compareAll();
        end
    endtask

    logic [2:0] pick;
    int sel;

    initial begin
        mod4 = resetModel();
        mod2 = resetModel();
        @(negedge clk);
        applyStimulus(3'b000, 1'b1, 2);
        applyStimulus(3'b000, 1'b0, 10);
        applyStimulus(3'b001, 1'b0, 10);
        applyStimulus(3'b011, 1'b0, 10);
        applyStimulus(3'b111, 1'b0, 3);
        applyStimulus(3'b011, 1'b0, 10);
        applyStimulus(3'b101, 1'b0, 10);
        applyStimulus(3'b111, 1'b0, 12);
        applyStimulus(3'b001, 1'b0, 10);
        applyStimulus(3'b011, 1'b0, 4);
        applyStimulus(3'b011, 1'b1, 1);
        applyStimulus(3'b011, 1'b0, 12);
        applyStimulus(3'b010, 1'b0, 10);
        applyStimulus(3'b010, 1'b1, 2);
        applyStimulus(3'b010, 1'b0, 10);
        applyStimulus(3'b000, 1'b0, 10);

        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                case ($urandom_range(0, 3))
                    0: pick = 3'b000;
                    1: pick = 3'b001;
                    2: pick = 3'b011;
                    default: pick = 3'b111;
                endcase
            end else begin
                pick = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 29) == 0)
                applyStimulus(pick, 1'b1, $urandom_range(1, 2));
            else if (sel == 9)
                applyStimulus(pick, 1'b0, $urandom_range(1, 3));
            else
                applyStimulus(pick, 1'b0, $urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
